// File: rtl/axil_io_pkg.sv
// rtl/axil_io_pkg.sv - shared constants, FSM state types and byte-lane helpers for axil_io_slave
package axil_io_pkg;

  // Register word offsets (byte address bits [3:2])
  localparam logic [1:0] ADDR_OUT_DATA = 2'd0;
  localparam logic [1:0] ADDR_OUT_EN   = 2'd1;
  localparam logic [1:0] ADDR_IN_DATA  = 2'd2;
  localparam logic [1:0] ADDR_SCRATCH  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = strb_mask(strb);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/axil_io_sync.sv
// rtl/axil_io_sync.sv - 2-flop gpio input synchronizer; edge detect output when AXIL_IO_IRQ_EN is defined
module axil_io_sync
  import axil_io_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
`ifdef AXIL_IO_IRQ_EN
  output logic [WIDTH-1:0] toggle,
`endif
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

`ifdef AXIL_IO_IRQ_EN
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= sync_q;
  end

  // One-cycle pulse on either edge of the synchronized level
  assign toggle = sync_q ^ prev_q;
`endif

endmodule

// File: rtl/axil_io_slave.sv
// rtl/axil_io_slave.sv - AXI4-Lite GPIO register slave; AXIL_IO_IRQ_EN turns 0xC into W1C IRQ_STATUS with irq output
module axil_io_slave
  import axil_io_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          GPIO_WIDTH         = 32,
  parameter logic [31:0] OUT_RESET          = 32'h0
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic [GPIO_WIDTH-1:0]         gpio_in,
`ifdef AXIL_IO_IRQ_EN
  output logic                          irq,
`endif
  output logic [GPIO_WIDTH-1:0]         gpio_out,
  output logic [GPIO_WIDTH-1:0]         gpio_oe
);

  localparam logic [31:0] GPIO_MASK =
    (GPIO_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << GPIO_WIDTH) - 32'd1);

  wr_state_t   wr_state;
  rd_state_t   rd_state;
  logic [1:0]  aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] out_data_q;
  logic [31:0] out_en_q;
  logic [GPIO_WIDTH-1:0] in_sync;

  logic        aw_hs, w_hs, ar_hs;
  logic        commit;
  logic [1:0]  c_addr;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  logic [31:0] rd_mux;

  logic unused_inputs;
  assign unused_inputs = ^{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

`ifdef AXIL_IO_IRQ_EN
  logic [GPIO_WIDTH-1:0] in_toggle;
  logic [GPIO_WIDTH-1:0] irq_status_q;
  logic                  irq_q;
  logic [31:0]           clr_full;

  axil_io_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .din    (gpio_in),
    .toggle (in_toggle),
    .dout   (in_sync)
  );
`else
  logic [31:0] scratch_q;

  axil_io_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .din   (gpio_in),
    .dout  (in_sync)
  );
`endif

  assign S_AXI_AWREADY = (wr_state == W_IDLE) || (wr_state == W_HAVE_W);
  assign S_AXI_WREADY  = (wr_state == W_IDLE) || (wr_state == W_HAVE_AW);
  assign S_AXI_BVALID  = (wr_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (rd_state == R_IDLE);
  assign S_AXI_RVALID  = (rd_state == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // The commit takes whichever half arrives now and the latched copy of the other
  always_comb begin
    commit = 1'b0;
    c_addr = aw_addr_q;
    c_data = w_data_q;
    c_strb = w_strb_q;
    case (wr_state)
      W_IDLE: if (aw_hs && w_hs) begin
        commit = 1'b1;
        c_addr = S_AXI_AWADDR[3:2];
        c_data = S_AXI_WDATA;
        c_strb = S_AXI_WSTRB;
      end
      W_HAVE_AW: if (w_hs) begin
        commit = 1'b1;
        c_data = S_AXI_WDATA;
        c_strb = S_AXI_WSTRB;
      end
      W_HAVE_W: if (aw_hs) begin
        commit = 1'b1;
        c_addr = S_AXI_AWADDR[3:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state  <= W_IDLE;
      aw_addr_q <= 2'd0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state <= W_RESP;
          end else if (aw_hs) begin
            aw_addr_q <= S_AXI_AWADDR[3:2];
            wr_state  <= W_HAVE_AW;
          end else if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
            wr_state <= W_HAVE_W;
          end
        end
        W_HAVE_AW: if (w_hs)  wr_state <= W_RESP;
        W_HAVE_W:  if (aw_hs) wr_state <= W_RESP;
        W_RESP:    if (S_AXI_BREADY) wr_state <= W_IDLE;
        default:   wr_state <= W_IDLE;
      endcase
      if (commit) bresp_q <= (c_addr == ADDR_IN_DATA) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      out_data_q <= OUT_RESET & GPIO_MASK;
      out_en_q   <= 32'h0;
`ifndef AXIL_IO_IRQ_EN
      scratch_q  <= 32'h0;
`endif
    end else if (commit) begin
      case (c_addr)
        ADDR_OUT_DATA: out_data_q <= strb_merge(out_data_q, c_data, c_strb) & GPIO_MASK;
        ADDR_OUT_EN:   out_en_q   <= strb_merge(out_en_q, c_data, c_strb) & GPIO_MASK;
`ifndef AXIL_IO_IRQ_EN
        ADDR_SCRATCH:  scratch_q  <= strb_merge(scratch_q, c_data, c_strb);
`endif
        default: ;
      endcase
    end
  end

`ifdef AXIL_IO_IRQ_EN
  assign clr_full = (commit && (c_addr == ADDR_SCRATCH)) ? (c_data & strb_mask(c_strb)) : 32'h0;

  // A new edge in the clearing cycle is ORed in after the clear, so it survives
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      irq_status_q <= (irq_status_q & ~clr_full[GPIO_WIDTH-1:0]) | in_toggle;
      irq_q        <= |irq_status_q;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rd_mux = 32'h0;
    case (S_AXI_ARADDR[3:2])
      ADDR_OUT_DATA: rd_mux = out_data_q;
      ADDR_OUT_EN:   rd_mux = out_en_q;
      ADDR_IN_DATA:  rd_mux = 32'(in_sync);
`ifdef AXIL_IO_IRQ_EN
      ADDR_SCRATCH:  rd_mux = 32'(irq_status_q);
`else
      ADDR_SCRATCH:  rd_mux = scratch_q;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state <= R_IDLE;
      rdata_q  <= 32'h0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (ar_hs) begin
          rdata_q  <= rd_mux;
          rresp_q  <= RESP_OKAY;
          rd_state <= R_DATA;
        end
        R_DATA: if (S_AXI_RREADY) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign gpio_out = out_data_q[GPIO_WIDTH-1:0];
  assign gpio_oe  = out_en_q[GPIO_WIDTH-1:0];

endmodule
